// File: rtl/adder_12in_1bit_if.sv
// Operand/result bundle for the 12-input popcount adder.
// master drives the operand side, slave is the adder itself.
interface adder_12in_1bit_if #(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_OUT = 4
);
  logic                i_valid;
  logic [WIDTH_IN-1:0] i_a;
  logic [WIDTH_OUT:0]  o_sum;
  logic                o_valid;

  modport master (output i_valid, output i_a, input o_sum, input o_valid);
  modport slave  (input i_valid, input i_a, output o_sum, output o_valid);
endinterface

// File: rtl/adder_12in_1bit.sv
// Pipelined ones-count of a 12-bit vector.
// Stage 1: one full adder per 3-bit group (carry-save).
// Stage 2: second FA level plus ripple adder into the registered result.
// Optional macro ADDER_12IN_1BIT_REG_IN_EN adds an input register stage
// (latency 3 instead of 2); results are otherwise identical.

module adder_12in_1bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_12in_1bit #(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_OUT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  adder_12in_1bit_if.slave   bus
);
  localparam int NUM_GRP = WIDTH_IN / 3;

  // The compressor tree below is laid out for exactly four 3-bit groups.
  if (WIDTH_IN != 12 || WIDTH_OUT < 3) begin : g_bad_cfg
    $error("adder_12in_1bit: tree supports WIDTH_IN=12, WIDTH_OUT>=3 only");
  end

`ifdef ADDER_12IN_1BIT_REG_IN_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  // vld_all[0] is the live input strobe, [STAGES:1] are registered.
  logic [STAGES:1] vld_pipe;
  logic [STAGES:0] vld_all;
  logic            v_s1;   // operand entering stage 1 is valid
  logic            v_s2;   // stage-1 registers hold a valid operand

  assign vld_all = {vld_pipe, bus.i_valid};
  assign v_s1    = vld_all[STAGES-2];
  assign v_s2    = vld_all[STAGES-1];

  // Valid shift register; reset drops everything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld_pipe <= '0;
    else       vld_pipe <= vld_all[STAGES-1:0];
  end

  logic [WIDTH_IN-1:0] a_s1;

`ifdef ADDER_12IN_1BIT_REG_IN_EN
  logic [WIDTH_IN-1:0] a_in_q;

  // Input register; only captures on valid so idle X never enters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            a_in_q <= '0;
    else if (bus.i_valid) a_in_q <= bus.i_a;
  end

  assign a_s1 = a_in_q;
`else
  assign a_s1 = bus.i_a;
`endif

  // ---------------- stage 1: per-group full adders ----------------
  logic [NUM_GRP-1:0] grp_s, grp_c;
  logic [NUM_GRP-1:0] s_q, c_q;

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    adder_12in_1bit_fa u_fa (
      .a  (a_s1[3*g]),
      .b  (a_s1[3*g+1]),
      .ci (a_s1[3*g+2]),
      .s  (grp_s[g]),
      .co (grp_c[g])
    );
  end

  // Capture group sums/carries; held on bubbles so X can't leak forward.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q <= '0;
      c_q <= '0;
    end else if (v_s1) begin
      s_q <= grp_s;
      c_q <= grp_c;
    end
  end

  // ---------------- stage 2: second FA level + ripple ----------------
  // Weights: s_q bits are 1, c_q bits are 2.
  logic a_s, a_c;  // FA(s0,s1,s2): a_s w1, a_c w2
  logic b_s, b_c;  // FA(c0,c1,c2): b_s w2, b_c w4
  logic d_s, d_c;  // FA(a_c,b_s,c3): d_s w2, d_c w4

  adder_12in_1bit_fa u_fa_s (.a(s_q[0]), .b(s_q[1]), .ci(s_q[2]), .s(a_s), .co(a_c));
  adder_12in_1bit_fa u_fa_c (.a(c_q[0]), .b(c_q[1]), .ci(c_q[2]), .s(b_s), .co(b_c));
  adder_12in_1bit_fa u_fa_m (.a(a_c),    .b(b_s),    .ci(c_q[3]), .s(d_s), .co(d_c));

  // Two remaining operands: {b_c,d_s,a_s} + {d_c,0,s3}, zero-extended.
  logic [WIDTH_OUT-1:0] op_x, op_y;
  always_comb begin
    op_x      = '0;
    op_y      = '0;
    op_x[2:0] = {b_c, d_s, a_s};
    op_y[2:0] = {d_c, 1'b0, s_q[3]};
  end

  logic [WIDTH_OUT:0] rc;     // rc[i] is the carry into bit i
  logic [WIDTH_OUT:0] sum_d;

  assign rc[0] = 1'b0;
  for (genvar i = 0; i < WIDTH_OUT; i++) begin : g_rip
    adder_12in_1bit_fa u_fa (
      .a  (op_x[i]),
      .b  (op_y[i]),
      .ci (rc[i]),
      .s  (sum_d[i]),
      .co (rc[i+1])
    );
  end
  assign sum_d[WIDTH_OUT] = rc[WIDTH_OUT];

  logic [WIDTH_OUT:0] sum_q;

  // Result register updates only on a valid operand, otherwise holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     sum_q <= '0;
    else if (v_s2) sum_q <= sum_d;
  end

  assign bus.o_sum   = sum_q;
  assign bus.o_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_adder_12in_1bit.sv
// Directed bench for adder_12in_1bit: hand-computed counts are queued per
// step and compared when they are due at the output.
module tb_adder_12in_1bit;
`ifdef ADDER_12IN_1BIT_REG_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  adder_12in_1bit_if #(.WIDTH_IN(12), .WIDTH_OUT(4)) bus ();

  adder_12in_1bit #(.WIDTH_IN(12), .WIDTH_OUT(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // expected-output history, index 0 = most recent step
  logic       hv [LAT];
  logic [4:0] hs [LAT];
  logic [4:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < LAT; i++) begin
      hv[i] = 1'b0;
      hs[i] = '0;
    end
    held = '0;
  endtask

  // Called at a negedge: drive one operand, advance one cycle, check the
  // output due now (from LAT-1 steps back) and the hold behaviour.
  task automatic step(input logic [11:0] a, input logic v, input logic [4:0] es,
                      input string tag);
    bus.i_a     = a;
    bus.i_valid = v;
    @(posedge i_clk);
    @(negedge i_clk);
    for (int i = LAT - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      hs[i] = hs[i-1];
    end
    hv[0] = v;
    hs[0] = es;
    chk({tag, ".valid"}, {31'd0, bus.o_valid}, {31'd0, hv[LAT-1]});
    if (hv[LAT-1]) held = hs[LAT-1];
    chk({tag, ".sum"}, {27'd0, bus.o_sum}, {27'd0, held});
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) step(12'h000, 1'b0, 5'd0, "flush");
  endtask

  logic [11:0] a;

  initial begin
    bus.i_a     = '0;
    bus.i_valid = 1'b0;
    clear_hist();

    // reset state
    repeat (2) @(negedge i_clk);
    chk("reset.valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset.sum",   {27'd0, bus.o_sum},   32'd0);
    i_rst = 1'b0;

    step(12'h000, 1'b1, 5'd0, "zero");

    // walking fill 1..12
    a = 12'h000;
    for (int i = 0; i < 12; i++) begin
      a[i] = 1'b1;
      step(a, 1'b1, 5'(i + 1), $sformatf("fill%0d", i));
    end

    // walking clear 11..0
    a = 12'hFFF;
    for (int i = 0; i < 12; i++) begin
      a[i] = 1'b0;
      step(a, 1'b1, 5'(11 - i), $sformatf("clear%0d", i));
    end

    // even bits 10,8,..,0 -> 1..6 (12'h555), then odd 11,9,..,1 -> 7..12
    a = 12'h000;
    for (int k = 0; k < 6; k++) begin
      a[10 - 2*k] = 1'b1;
      step(a, 1'b1, 5'(k + 1), $sformatf("even%0d", k));
    end
    for (int k = 0; k < 6; k++) begin
      a[11 - 2*k] = 1'b1;
      step(a, 1'b1, 5'(k + 7), $sformatf("odd%0d", k));
    end

    // back-to-back patterns
    step(12'h800, 1'b1, 5'd1,  "p800");
    step(12'h00F, 1'b1, 5'd4,  "p00F");
    step(12'hAAA, 1'b1, 5'd6,  "pAAA");
    step(12'hFFE, 1'b1, 5'd11, "pFFE");

    // bubble: sum must hold at 12, X on idle input must not leak
    step(12'hFFF, 1'b1, 5'd12, "pFFF");
    step(12'h000, 1'b0, 5'd0,  "bubble");
    step(12'bx,   1'b0, 5'd0,  "xidle");
    step(12'h003, 1'b1, 5'd2,  "p003");
    flush();

    // async reset with two results in flight
    step(12'h00F, 1'b1, 5'd4, "pre0");
    step(12'h0FF, 1'b1, 5'd8, "pre1");
    bus.i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("arst.valid", {31'd0, bus.o_valid}, 32'd0);
    chk("arst.sum",   {27'd0, bus.o_sum},   32'd0);
    clear_hist();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    flush();  // nothing stale may come out
    step(12'hFFF, 1'b1, 5'd12, "post");
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
